cache_req_driver: RTL

- Initiator-side sequencer for the partitioned PLRU cacheline: buffers host commands, then drives the cache's os_req/hitmap/user_req/addr inputs one request at a time.
- Samples the cache's hit output and returns one response per access.
- Keeps saturating hit/miss/switch statistics and refuses accesses while no domain ways are enabled, so nothing is allocated outside a partition.

---
 rtl/cache_req_driver.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/cache_req_driver.sv
// Initiator-side sequencer for the partitioned PLRU cacheline: buffers host commands,
// issues one os/user request at a time, returns per-access responses and keeps statistics.
module cache_req_driver #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_WAYS   = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_is_os,
    input  logic [NUM_WAYS-1:0]   cmd_hitmap,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  os_req,
    output logic [NUM_WAYS-1:0]   hitmap,
    output logic                  user_req,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic                  hit,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic                  rsp_err,
    output logic [NUM_WAYS-1:0]   cur_hitmap,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt,
    output logic [CNT_WIDTH-1:0]  switch_cnt,
    output logic                  busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic                  is_os;
        logic [NUM_WAYS-1:0]   hitmap;
        logic [ADDR_WIDTH-1:0] addr;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state, state_d;

    cmd_t                  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [OCC_W-1:0]      occ, occ_d;

    logic                  cur_is_os, cur_is_os_d;
    logic                  cur_drop, cur_drop_d;

    logic                  push_c, load_c, empty_c, cap_c, count_c;
    cmd_t                  head_c;

    logic                  cmd_ready_d, busy_d;
    logic                  os_req_d, user_req_d;
    logic [NUM_WAYS-1:0]   hitmap_d, cur_hitmap_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  rsp_valid_d, rsp_hit_d, rsp_err_d;
    logic [CNT_WIDTH-1:0]  hit_cnt_d, miss_cnt_d, switch_cnt_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign push_c  = cmd_valid && cmd_ready;
    assign empty_c = (occ == '0);
    assign head_c  = mem[rd_ptr];

    // Command storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= cmd_t'{is_os: cmd_is_os, hitmap: cmd_hitmap, addr: cmd_addr};
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state;
        load_c       = 1'b0;
        occ_d        = occ;
        cur_is_os_d  = cur_is_os;
        cur_drop_d   = cur_drop;
        os_req_d     = 1'b0;
        user_req_d   = 1'b0;
        hitmap_d     = '0;
        addr_d       = '0;
        cur_hitmap_d = cur_hitmap;
        rsp_valid_d  = 1'b0;
        rsp_hit_d    = 1'b0;
        rsp_err_d    = 1'b0;
        hit_cnt_d    = hit_cnt;
        miss_cnt_d   = miss_cnt;
        switch_cnt_d = switch_cnt;
        cap_c        = 1'b0;
        count_c      = 1'b0;

        case (state)
            IDLE: begin
                if (!empty_c) begin
                    load_c  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!cur_is_os) begin
                    state_d = CAPTURE;
                end else if (!empty_c) begin
                    load_c = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                cap_c = 1'b1;
                if (!empty_c) begin
                    load_c  = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A popped head becomes the request pulse visible during the following cycle.
        if (load_c) begin
            cur_is_os_d = head_c.is_os;
            cur_drop_d  = !head_c.is_os && (cur_hitmap == '0);
            if (head_c.is_os) begin
                os_req_d     = 1'b1;
                hitmap_d     = head_c.hitmap;
                cur_hitmap_d = head_c.hitmap;
                switch_cnt_d = sat_inc(switch_cnt);
            end else if (cur_hitmap != '0) begin
                user_req_d = 1'b1;
                addr_d     = head_c.addr;
            end
        end

        if (cap_c) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = cur_drop;
            rsp_hit_d   = !cur_drop && hit;
            count_c     = !cur_drop;
        end
        if (count_c) begin
            if (hit) hit_cnt_d  = sat_inc(hit_cnt);
            else     miss_cnt_d = sat_inc(miss_cnt);
        end

        case ({push_c, load_c})
            2'b10:   occ_d = occ + OCC_W'(1);
            2'b01:   occ_d = occ - OCC_W'(1);
            default: occ_d = occ;
        endcase

        cmd_ready_d = (occ_d != OCC_W'(FIFO_DEPTH));
        busy_d      = (occ_d != '0) || (state_d != IDLE);
    end

    // State, pointers and all outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            cur_is_os  <= 1'b0;
            cur_drop   <= 1'b0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            os_req     <= 1'b0;
            hitmap     <= '0;
            user_req   <= 1'b0;
            addr       <= '0;
            rsp_valid  <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_err    <= 1'b0;
            cur_hitmap <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            switch_cnt <= '0;
        end else begin
            state      <= state_d;
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load_c) rd_ptr <= rd_ptr + PTR_W'(1);
            occ        <= occ_d;
            cur_is_os  <= cur_is_os_d;
            cur_drop   <= cur_drop_d;
            cmd_ready  <= cmd_ready_d;
            busy       <= busy_d;
            os_req     <= os_req_d;
            hitmap     <= hitmap_d;
            user_req   <= user_req_d;
            addr       <= addr_d;
            rsp_valid  <= rsp_valid_d;
            rsp_hit    <= rsp_hit_d;
            rsp_err    <= rsp_err_d;
            cur_hitmap <= cur_hitmap_d;
            hit_cnt    <= hit_cnt_d;
            miss_cnt   <= miss_cnt_d;
            switch_cnt <= switch_cnt_d;
        end
    end

endmodule
